// File: rtl/host_iface_pkg.sv
// Shared types for the host output arbiter: FSM state encoding and index-width helper.
package host_iface_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    // One extra bit keeps the index non-zero width even for a single source.
    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after last_src+1 (mod N_SRCS).
module rr_pick
    import host_iface_pkg::*;
#(
    parameter int unsigned N_SRCS = 2,
    localparam int unsigned IDX_W = idx_w(N_SRCS)
) (
    input  logic [N_SRCS-1:0] req_i,
    input  logic [IDX_W-1:0]  last_src_i,
    output logic [IDX_W-1:0]  winner_o,
    output logic              any_o
);

    logic [N_SRCS-1:0] rot;
    logic              found;
    int unsigned       k;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        rot      = '0;
        k        = 0;
        for (int unsigned i = 0; i < N_SRCS; i++) begin
            k   = (32'(last_src_i) + 32'(1) + i) % N_SRCS;
            rot = req_i >> k;
            if (!found && rot[0]) begin
                winner_o = IDX_W'(k);
                found    = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/out_arb.sv
// Round-robin arbiter multiplexing N_SRCS byte writers onto one acked host link.
// OUT_ARB_FRAME_EN: grants end on an acked byte flagged by omux_last_i instead of after MAX_BURST bytes.
module out_arb
    import host_iface_pkg::*;
#(
    parameter int unsigned N_SRCS    = 2,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned IDX_W    = idx_w(N_SRCS),
    localparam int unsigned CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_SRCS*DATA_W-1:0] omux_data_i,
    input  logic [N_SRCS-1:0]        omux_req_i,
`ifdef OUT_ARB_FRAME_EN
    input  logic [N_SRCS-1:0]        omux_last_i,
`endif
    output logic [N_SRCS-1:0]        omux_sel_o,
    output logic [DATA_W-1:0]        out_o,
    output logic                     out_req_o,
    input  logic                     out_ack_i,
    output logic [IDX_W-1:0]         grant_o,
    output logic                     busy_o
);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  cur_src_q, cur_src_d;
    logic [IDX_W-1:0]  last_src_q, last_src_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic [N_SRCS-1:0] req_shift;
    logic              cur_req;
`ifdef OUT_ARB_FRAME_EN
    logic              last_flag_q, last_flag_d;
    logic [N_SRCS-1:0] last_shift;

    assign last_shift = omux_last_i >> cur_src_q;
`endif

    rr_pick #(
        .N_SRCS(N_SRCS)
    ) u_rr_pick (
        .req_i     (omux_req_i),
        .last_src_i(last_src_q),
        .winner_o  (winner),
        .any_o     (any_req)
    );

    assign req_shift = omux_req_i >> cur_src_q;
    assign cur_req   = req_shift[0];
    assign cnt_inc   = burst_cnt_q + CNT_W'(1);
    assign out_o     = DATA_W'(omux_data_i >> (32'(cur_src_q) * DATA_W));
    assign grant_o   = cur_src_q;
    assign busy_o    = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cur_src_q   <= '0;
            last_src_q  <= IDX_W'(N_SRCS - 1);
            burst_cnt_q <= '0;
`ifdef OUT_ARB_FRAME_EN
            last_flag_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            last_src_q  <= last_src_d;
            burst_cnt_q <= burst_cnt_d;
`ifdef OUT_ARB_FRAME_EN
            last_flag_q <= last_flag_d;
`endif
        end
    end

    // Next-state and link handshake; last_src advances only when a grant ends.
    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        last_src_d  = last_src_q;
        burst_cnt_d = burst_cnt_q;
        out_req_o   = 1'b0;
        omux_sel_o  = '0;
`ifdef OUT_ARB_FRAME_EN
        last_flag_d = last_flag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    cur_src_d   = winner;
                    burst_cnt_d = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (cur_req) begin
                    out_req_o  = 1'b1;
                    omux_sel_o = N_SRCS'(1) << cur_src_q;
                    state_d    = WAIT;
`ifdef OUT_ARB_FRAME_EN
                    last_flag_d = last_shift[0];
`endif
                end else begin
                    state_d    = IDLE;
                    last_src_d = cur_src_q;
                end
            end
            WAIT: begin
                if (out_ack_i) begin
                    burst_cnt_d = (burst_cnt_q == CNT_W'(MAX_BURST)) ? burst_cnt_q : cnt_inc;
`ifdef OUT_ARB_FRAME_EN
                    if (last_flag_q) begin
`else
                    if (cnt_inc == CNT_W'(MAX_BURST)) begin
`endif
                        state_d    = IDLE;
                        last_src_d = cur_src_q;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/out_arb.md
OUT_ARB -- requirements
Module: out_arb

Interface
REQ-001 Parameter N_SRCS, default 2: number of writer sources, 1..16.
REQ-002 Parameter DATA_W, default 8: byte-lane width per source.
REQ-003 Parameter MAX_BURST, default 16: maximum bytes per grant before re-arbitration, 1..255.
REQ-004 clk_i  in  1  the only clock; all state updates on its rising edge.
REQ-005 reset_i  in  1  asynchronous, active-high reset.
REQ-006 omux_data_i  in  N_SRCS*DATA_W  per-source data; slice k = bits [k*DATA_W +: DATA_W].
REQ-007 omux_req_i  in  N_SRCS  per-source request, level, held while the source has bytes.
REQ-008 omux_sel_o  out  N_SRCS  one-hot select; source k presents its byte and advances when bit k is high.
REQ-009 out_o  out  DATA_W  byte to the host link.
REQ-010 out_req_o  out  1  byte valid to the host link.
REQ-011 out_ack_i  in  1  host link has consumed the byte.
REQ-012 grant_o  out  $clog2(N_SRCS)+1  index of the current owner; valid when busy_o is high.
REQ-013 busy_o  out  1  high in SEND or WAIT.

Function
REQ-014 FSM states: IDLE, SEND, WAIT; SEND lasts exactly one cycle.
REQ-015 IDLE: if omux_req_i != 0, latch the round-robin winner into current_src, clear burst_cnt, go to SEND; otherwise stay.
REQ-016 Round-robin: search starts at last_src+1 mod N_SRCS and takes the first requester; last_src updates when a grant ends.
REQ-017 SEND with omux_req_i[current_src]=1: out_req_o=1, omux_sel_o=1<<current_src, go to WAIT.
REQ-018 SEND with omux_req_i[current_src]=0: out_req_o=0, omux_sel_o=0, go to IDLE; no byte is issued.
REQ-019 WAIT: out_req_o=0, omux_sel_o=0; hold until out_ack_i; an ack in SEND or IDLE is ignored.
REQ-020 WAIT with out_ack_i: burst_cnt+1; go to IDLE if the new count equals MAX_BURST, otherwise to SEND.
REQ-021 out_o = slice current_src of omux_data_i, combinational, guaranteed valid only in SEND.
REQ-022 burst_cnt width $clog2(MAX_BURST+1) bits, with no wrap: it is cleared at each grant.
REQ-023 A source that drops its request mid-burst loses the grant at the next SEND, per REQ-018.
REQ-024 A single continuous requester is re-granted after one IDLE bubble cycle every MAX_BURST bytes.
REQ-025 With MAX_BURST=1, sources interleave byte by byte.

Reset
REQ-026 reset_i high: state=IDLE, current_src=0, last_src=N_SRCS-1 (source 0 wins first), burst_cnt=0, immediately and asynchronously.
REQ-027 During reset: out_req_o=0, omux_sel_o=0, busy_o=0, grant_o=0.
REQ-028 Reset mid-WAIT abandons the byte; any later out_ack_i is ignored until the next SEND.

Configuration
REQ-029 OUT_ARB_FRAME_EN defined: adds input omux_last_i[N_SRCS].
REQ-030 With OUT_ARB_FRAME_EN, the grant ends only on an acked byte with omux_last_i[current_src] sampled high in SEND; MAX_BURST is ignored.
REQ-031 Without OUT_ARB_FRAME_EN, the omux_last_i port does not exist and REQ-020 applies.

Structure
REQ-032 Package host_iface_pkg holds the FSM state typedef (IDLE=0, SEND=1, WAIT=2) and the index-width constant function.
REQ-033 Sub-module rr_pick contains the combinational round-robin picker: inputs req vector and last_src; outputs winner index and any-request flag.

Verification
REQ-034 N_SRCS=2, both requesting from reset, ack 1 cycle after each out_req_o -> grants 0,1,0,1, 16 bytes each.
REQ-035 Source 1 alone, 40 bytes, MAX_BURST=16 -> bursts of 16, 16, 8 with exactly one IDLE cycle between bursts.
REQ-036 Source 0 drops its request after 5 acks -> no 6th out_req_o; source 1 is granted two cycles later.
REQ-037 reset_i asserted in WAIT, ack arrives after release -> out_req_o stays 0, ack is ignored, next grant goes to source 0.
REQ-038 OUT_ARB_FRAME_EN, source 0 sends a 40-byte frame with last on byte 40 while source 1 requests -> 40 contiguous bytes from source 0, then source 1.
REQ-039 N_SRCS=4, MAX_BURST=1, requests 0, 2, 3 held -> byte order 0,2,3,0,2,3; out_o matches the selected slice in every SEND.
